xor_share_arbiter: RTL and testbench
====================================

Name: xor_share_arbiter

Overview:
- Shares a single `xor_32b` bitwise-XOR datapath between two requesters.
- Arbitration is round-robin at packet granularity: a grant stays locked to one requester until its `last` beat is accepted.
- Each accepted operand pair (a, b) produces a registered result a^b tagged with the requester id.
- Sits between operand producers (ALU/checksum sequencers) and a single downstream consumer, using a valid/ready handshake on every interface.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported (fixed by `xor_32b`).
- MAX_BEATS, 16, maximum beats per locked packet before forced release; legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 beat valid.
- req0_a  in  32  requester 0 operand A.
- req0_b  in  32  requester 0 operand B.
- req0_last  in  1  requester 0 final beat of packet.
- req0_ready  out  1  requester 0 beat accepted this cycle (when req0_valid=1).
- req1_valid, req1_a, req1_b, req1_last, req1_ready: same as requester 0, for requester 1.
- out_valid  out  1  result register holds a valid beat.
- out_data  out  32  a^b of the accepted beat.
- out_id  out  1  requester that supplied the beat.
- out_last  out  1  beat closed its packet (normal or forced).
- out_ready  in  1  consumer accepts the result this cycle.
- busy  out  1  arbiter is locked to a requester (state != IDLE).
- burst_err  out  1  sticky; a packet hit MAX_BEATS without `last`.

Behaviour:
- Reset (synchronous, takes priority over all else):
  - out_valid, out_data, out_id, out_last, busy, burst_err = 0.
  - state = IDLE, beat_cnt = 0, rr_last = 1 (requester 0 wins the first tie).
  - Any pending output beat is discarded and any lock is released.
- State machine: IDLE, LOCK0, LOCK1.
- Output register free: can_take = !out_valid || out_ready.
- Grant (combinational):
  - IDLE: if exactly one reqN_valid, grant N. If both valid, grant the requester != rr_last.
  - LOCKn: grant only n; the other requester's ready is 0.
- reqN_ready = grant==N && can_take. Ready does not depend on reqN_valid; a beat is accepted when valid && ready.
- On an accepted beat from requester N (next cycle):
  - out_data = a^b via an `xor_32b` instance; out_id = N; out_valid = 1.
  - Latency is 1 cycle; throughput is 1 beat/cycle while out_ready=1.
  - beat_cnt increments.
  - The beat is final if reqN_last=1, or if beat_cnt+1 == MAX_BEATS (forced).
  - Final beat: out_last = 1, state → IDLE, rr_last = N, beat_cnt = 0. If forced and reqN_last=0, burst_err is set (sticky until reset).
  - Non-final beat: out_last = 0, state → LOCKN.
- If out_ready=1 and no beat is accepted, out_valid → 0. out_data, out_id and out_last hold their last values.
- While out_valid=1 and out_ready=0, the output register is held stable and all reqN_ready = 0.
- IDLE with no valid requester: no grant, state and rr_last unchanged.
- Single-beat packets (last=1 on the first beat) never leave IDLE, so the arbiter alternates per beat under contention.
- MAX_BEATS=1: every beat is final; burst_err sets on any beat with last=0.
- Requester drops valid while locked: the arbiter stays in LOCKn indefinitely; there is no timeout.
- busy = (state != IDLE), registered.

Test Plan:
1. Single beat: req0_valid=1, a=FFFF0000, b=0F0F0F0F, last=1, out_ready=1.
   - req0_ready=1 the same cycle.
   - Next cycle: out_valid=1, out_data=F0F00F0F, out_id=0, out_last=1, busy=0.
2. Contention: both requesters continuously valid with single-beat packets (req0 a^b=00000001, req1 a^b=00000002).
   - Outputs alternate id 0,1,0,1 with data 1,2,1,2, one result per cycle.
3. Packet lock: req0 sends 3 beats (last on beat 3) while req1_valid=1 throughout.
   - req1_ready stays 0 for 3 cycles and busy=1 after beat 1.
   - req1 is granted the cycle after req0's last beat is accepted.
   - Output ids 0,0,0,1, with out_last=1 on the third beat.
4. Backpressure: with out_valid=1, hold out_ready=0 for 4 cycles.
   - out_data, out_id and out_last are stable; req0_ready = req1_ready = 0.
   - When out_ready goes to 1, a pending valid beat is accepted that same cycle.
5. Forced release: MAX_BEATS=4, req0 sends 5 beats all with last=0.
   - Beat 4 produces out_last=1 and sets burst_err=1.
   - Arbiter returns to IDLE; with req1 valid, req1 is granted next.
   - Beat 5 from req0 waits for its next grant.
6. Reset mid-packet: assert reset for 1 cycle after beat 2 of a 3-beat req0 packet.
   - Next cycle: all outputs = 0, busy=0, burst_err=0.
   - With both requesters valid, the first grant after reset goes to req0.

Source files
------------

// File: rtl/xor_share_arbiter.sv
// xor_share_arbiter: round-robin, packet-locked sharing of one 32-bit XOR datapath between two requesters
module xor_32b (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   assign y = a ^ b;
endmodule

module xor_share_arbiter #(
   parameter int WIDTH     = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_last,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_last,
   output logic             req1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_id,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy,
   output logic             burst_err
);
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
   localparam logic [7:0] MB = 8'(MAX_BEATS);
   state_t state, state_next;
   logic [7:0] beat_cnt;
   logic rr_last, can_take, gnt_vld, gnt_id, sel_valid, sel_last, acc, fin;
   logic [WIDTH-1:0] sel_a, sel_b, xor_y;
   assign can_take = !out_valid || out_ready;
   assign gnt_vld = state != IDLE || req0_valid || req1_valid;
   // under contention in IDLE the requester that did not finish last wins
   assign gnt_id = state == LOCK1 || (state == IDLE && (req0_valid && req1_valid ? !rr_last : req1_valid));
   assign req0_ready = gnt_vld && !gnt_id && can_take;
   assign req1_ready = gnt_vld && gnt_id && can_take;
   assign sel_valid = gnt_id ? req1_valid : req0_valid;
   assign sel_last = gnt_id ? req1_last : req0_last;
   assign sel_a = gnt_id ? req1_a : req0_a;
   assign sel_b = gnt_id ? req1_b : req0_b;
   assign acc = gnt_vld && can_take && sel_valid;
   assign fin = sel_last || beat_cnt + 8'd1 == MB;
   assign busy = state != IDLE;
   xor_32b u_xor (.a(sel_a), .b(sel_b), .y(xor_y));
   always_comb begin
      state_next = state;
      if (acc) state_next = fin ? IDLE : gnt_id ? LOCK1 : LOCK0;
   end
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_next;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data <= '0;
         out_id <= 1'b0;
         out_last <= 1'b0;
         burst_err <= 1'b0;
         beat_cnt <= 8'd0;
         rr_last <= 1'b1;
      end else if (acc) begin
         out_valid <= 1'b1;
         out_data <= xor_y;
         out_id <= gnt_id;
         out_last <= fin;
         beat_cnt <= fin ? 8'd0 : beat_cnt + 8'd1;
         if (fin) rr_last <= gnt_id;
         if (fin && !sel_last) burst_err <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_xor_share_arbiter.sv
// tb_xor_share_arbiter: directed plan scenarios plus random traffic against a packet-level reference model
module tb_xor_share_arbiter;
   localparam int MAXB = 4;
   logic clk = 1'b0, reset;
   logic req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b, out_data;
   logic out_valid, out_id, out_last, out_ready, busy, burst_err;
   int tests = 0, fails = 0;
   int owner, beats, prev;
   logic [31:0] e_data;
   logic e_valid, e_id, e_last, e_err;

   always #5 clk = ~clk;

   xor_share_arbiter #(.WIDTH(32), .MAX_BEATS(MAXB)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_last(req1_last), .req1_ready(req1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .burst_err(burst_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      owner = -1; beats = 0; prev = 1;
      e_valid = 0; e_data = '0; e_id = 0; e_last = 0; e_err = 0;
   endtask

   task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic l);
      req0_valid = v; req0_a = a; req0_b = b; req0_last = l;
   endtask

   task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic l);
      req1_valid = v; req1_a = a; req1_b = b; req1_last = l;
   endtask

   // one cycle: inputs already applied at the falling edge; check, then advance the model across the rising edge
   task automatic cyc(input string tag);
      int g;
      bit room, v, l;
      #1;
      room = !e_valid || out_ready;
      if (owner >= 0) g = owner;
      else if (req0_valid && req1_valid) g = 1 - prev;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
      else g = -1;
      chk({tag, " req0_ready"}, req0_ready, room && g == 0);
      chk({tag, " req1_ready"}, req1_ready, room && g == 1);
      chk({tag, " out_valid"}, out_valid, e_valid);
      chk({tag, " out_data"}, out_data, e_data);
      chk({tag, " out_id"}, out_id, e_id);
      chk({tag, " out_last"}, out_last, e_last);
      chk({tag, " busy"}, busy, owner >= 0);
      chk({tag, " burst_err"}, burst_err, e_err);
      v = g == 0 ? req0_valid : g == 1 ? req1_valid : 1'b0;
      l = g == 0 ? req0_last : req1_last;
      if (reset) model_reset();
      else if (g >= 0 && v && room) begin
         e_valid = 1;
         e_data = g == 0 ? req0_a ^ req0_b : req1_a ^ req1_b;
         e_id = g[0];
         e_last = l || beats + 1 == MAXB;
         if (e_last) begin
            if (!l) e_err = 1;
            owner = -1; beats = 0; prev = g;
         end else begin
            owner = g; beats++;
         end
      end else if (out_ready) e_valid = 0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1; set0(0, 0, 0, 0); set1(0, 0, 0, 0); out_ready = 1;
      cyc("reset");
      reset = 0;
   endtask

   initial begin
      model_reset();
      reset = 1; out_ready = 1; set0(0, 0, 0, 0); set1(0, 0, 0, 0);
      @(negedge clk);
      do_reset();
      chk("rst out_valid", out_valid, 0);
      chk("rst busy", busy, 0);
      // 1: single beat
      set0(1, 32'hFFFF0000, 32'h0F0F0F0F, 1);
      #1 chk("t1 ready", req0_ready, 1);
      cyc("t1a");
      set0(0, 0, 0, 0);
      chk("t1 data", out_data, 32'hF0F00F0F);
      chk("t1 last", {out_valid, out_id, out_last, busy}, 4'b1010);
      cyc("t1b");
      // 2: contention with single-beat packets
      do_reset();
      set0(1, 0, 1, 1); set1(1, 0, 2, 1);
      for (int i = 0; i < 4; i++) begin
         cyc("t2");
         chk("t2 id", out_id, i % 2);
         chk("t2 data", out_data, i % 2 + 1);
      end
      // 3: packet lock
      do_reset();
      set1(1, 32'h5, 32'h6, 1);
      for (int i = 1; i <= 3; i++) begin
         set0(1, i, 32'h100, i == 3);
         #1 chk("t3 r1 blocked", req1_ready, 0);
         cyc("t3");
         chk("t3 id", out_id, 0);
      end
      chk("t3 last", out_last, 1);
      set0(0, 0, 0, 0);
      #1 chk("t3 r1 granted", req1_ready, 1);
      cyc("t3b");
      chk("t3 id1", out_id, 1);
      // 4: backpressure
      do_reset();
      set0(1, 32'hA5A5A5A5, 32'h0000FFFF, 1);
      cyc("t4a");
      set1(1, 32'h3, 32'h4, 1); out_ready = 0;
      for (int i = 0; i < 4; i++) cyc("t4 hold");
      chk("t4 held data", out_data, 32'hA5A55A5A);
      out_ready = 1;
      #1 chk("t4 release", req1_ready, 1);
      cyc("t4b");
      // 5: forced release after MAX_BEATS
      do_reset();
      set1(1, 32'h7, 32'h0, 1);
      for (int i = 1; i <= 4; i++) begin
         set0(1, i, 0, 0);
         cyc("t5");
      end
      chk("t5 forced last", out_last, 1);
      chk("t5 burst_err", burst_err, 1);
      set0(1, 5, 0, 0);
      #1 chk("t5 r1 next", req1_ready, 1);
      cyc("t5b");
      set1(0, 0, 0, 0);
      cyc("t5c");
      chk("t5 beat5", out_data, 5);
      // 6: reset mid-packet
      do_reset();
      set1(1, 32'h9, 32'h0, 1);
      for (int i = 1; i <= 2; i++) begin
         set0(1, i, 0, 0);
         cyc("t6");
      end
      reset = 1;
      cyc("t6 rst");
      reset = 0;
      chk("t6 cleared", {out_valid, out_data, out_id, out_last, busy, burst_err}, 0);
      set0(1, 3, 0, 1);
      #1 chk("t6 first grant", req0_ready, 1);
      cyc("t6b");
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         reset = $urandom_range(0, 299) == 0;
         set0($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) == 0);
         set1($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) == 0);
         out_ready = $urandom_range(0, 3) != 0;
         cyc("rnd");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
